// File: rtl/spi_slave.sv
// SPI slave with all four CPOL/CPHA modes, sampled entirely in the sys_clk domain.
// Byte-oriented: tx_data is latched per byte; received bytes appear on data_out with an rx_valid pulse.
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              nCS,
  input  logic              DCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_taken,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;
  state_t state, state_nxt;

  logic ncs_s1, ncs_s2, ncs_d;
  logic dclk_s1, dclk_s2, dclk_d;
  logic mosi_s1, mosi_s2;

  logic [DATA_W-1:0] rx_shift, tx_shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic              skip_shift;

  logic ncs_fall, dclk_edge, lead_edge, trail_edge, sample_edge, shift_edge, last_bit;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ncs_s1  <= 1'b1;
      ncs_s2  <= 1'b1;
      ncs_d   <= 1'b1;
      dclk_s1 <= 1'b0;
      dclk_s2 <= 1'b0;
      dclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      ncs_s1  <= nCS;
      ncs_s2  <= ncs_s1;
      ncs_d   <= ncs_s2;
      dclk_s1 <= DCLK;
      dclk_s2 <= dclk_s1;
      dclk_d  <= dclk_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  // Edge classification relative to the idle level, then mapped to sample/shift by CPHA
  assign ncs_fall    = ncs_d & ~ncs_s2;
  assign dclk_edge   = dclk_s2 ^ dclk_d;
  assign lead_edge   = dclk_edge & (dclk_s2 != CPOL);
  assign trail_edge  = dclk_edge & (dclk_s2 == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign last_bit    = (bit_cnt == CNT_W'(DATA_W - 1));

  assign busy = ~ncs_s2;
  assign MISO = ncs_s2 ? 1'b0 : tx_shift[DATA_W-1];

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ncs_fall) state_nxt = LOAD;
      LOAD: state_nxt = XFER;
      XFER: begin
        if (ncs_s2)                       state_nxt = IDLE;
        else if (sample_edge && last_bit) state_nxt = DONE;
      end
      DONE: state_nxt = ncs_s2 ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // skip_shift suppresses exactly one shift edge: the first leading edge of a byte
  // in CPHA=1, or the trailing edge after the last sample in CPHA=0.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      data_out   <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      bit_cnt    <= '0;
      skip_shift <= 1'b0;
      rx_valid   <= 1'b0;
      tx_taken   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_taken  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          rx_shift   <= '0;
          bit_cnt    <= '0;
          skip_shift <= 1'b0;
        end
        LOAD: begin
          tx_shift   <= tx_data;
          tx_taken   <= 1'b1;
          bit_cnt    <= '0;
          skip_shift <= CPHA | (skip_shift & ~shift_edge);
        end
        XFER: begin
          if (ncs_s2) begin
            frame_err <= (bit_cnt != '0);
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s2};
            bit_cnt  <= bit_cnt + 1'b1;
            if (last_bit && !CPHA) skip_shift <= 1'b1;
          end else if (shift_edge) begin
            if (skip_shift) skip_shift <= 1'b0;
            else            tx_shift   <= {tx_shift[DATA_W-2:0], tx_shift[DATA_W-1]};
          end
        end
        DONE: begin
          data_out <= rx_shift;
          rx_valid <= 1'b1;
          if (shift_edge) skip_shift <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave; a bit-level SPI master drives the DUT and the
// expected results follow from the protocol: the slave receives what the master sent, the master reads tx_data.
module tb_spi_slave;

  logic       sys_clk = 1'b0;
  logic       rst, nCS, DCLK, MOSI, MISO, CPOL, CPHA;
  logic [7:0] tx_data, data_out;
  logic       tx_taken, rx_valid, busy, frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed-event bookkeeping
  logic [7:0] rx_got[$];
  int         tk_snap[$];
  int         n_taken = 0;
  int         n_ferr  = 0;
  int         n_rv    = 0;

  // Frame description used by run_frame
  logic [7:0] fm_mo[4];
  logic [7:0] fm_tx[5];
  logic [7:0] fm_mi[4];
  int         base_tk;

  spi_slave dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .nCS      (nCS),
    .DCLK     (DCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
    .tx_data  (tx_data),
    .tx_taken (tx_taken),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      rx_got.push_back(data_out);
      tk_snap.push_back(n_taken);
      n_rv++;
    end
    if (tx_taken)  n_taken++;
    if (frame_err) n_ferr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Half a DCLK period: DCLK = sys_clk/10
  task automatic half();
    cyc(5);
  endtask

  // Master side of one byte (or a truncated byte of nbits); tx_data moves to next_tx after the first bit
  task automatic spi_byte(input logic [7:0] mo, input logic [7:0] next_tx, input int nbits,
                          output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!CPHA) begin
        MOSI = mo[i];
        half();
        DCLK  = ~CPOL;
        mi[i] = MISO;
        half();
        DCLK  = CPOL;
      end else begin
        half();
        DCLK = ~CPOL;
        MOSI = mo[i];
        half();
        DCLK  = CPOL;
        mi[i] = MISO;
      end
      if (i == 7) tx_data = next_tx;
    end
  endtask

  task automatic run_frame(input logic cpol, input logic cpha, input int nb);
    CPOL    = cpol;
    CPHA    = cpha;
    DCLK    = cpol;
    MOSI    = 1'b0;
    tx_data = fm_tx[0];
    cyc(4);
    rx_got.delete();
    tk_snap.delete();
    base_tk = n_taken;
    nCS = 1'b0;
    cyc(8);
    for (int b = 0; b < nb; b++) spi_byte(fm_mo[b], fm_tx[b+1], 8, fm_mi[b]);
    half();
    nCS = 1'b1;
    cyc(10);
  endtask

  task automatic check_frame(input string tag, input int nb);
    chk({tag, " rx_count"}, rx_got.size(), nb);
    for (int b = 0; b < nb; b++) begin
      chk($sformatf("%s rx[%0d]", tag, b), (b < rx_got.size()) ? rx_got[b] : 8'hxx, fm_mo[b]);
      chk($sformatf("%s miso[%0d]", tag, b), fm_mi[b], fm_tx[b]);
      chk($sformatf("%s taken_before_rx[%0d]", tag, b),
          (b < tk_snap.size()) ? tk_snap[b] - base_tk : -1, b + 1);
    end
    chk({tag, " data_out"}, data_out, fm_mo[nb-1]);
  endtask

  initial begin
    logic [7:0] junk;
    int         b_rv, b_tk, b_fe;
    rst = 1'b1; nCS = 1'b1; DCLK = 1'b0; MOSI = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; tx_data = 8'h00;
    cyc(3);
    chk("reset data_out", data_out, 8'h00);
    chk("reset MISO", MISO, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset tx_taken", tx_taken, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    rst = 1'b0;
    cyc(4);

    // Mode 0 single byte
    fm_mo[0] = 8'hA5; fm_tx[0] = 8'h3C; fm_tx[1] = 8'h00;
    run_frame(1'b0, 1'b0, 1);
    check_frame("mode0", 1);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      fm_mo[0] = 8'h5A; fm_tx[0] = 8'hC3; fm_tx[1] = 8'h00;
      run_frame(m[1], m[0], 1);
      check_frame($sformatf("mode%0d", m), 1);
    end

    // Back-to-back bytes with nCS held low
    fm_mo[0] = 8'h01; fm_mo[1] = 8'h02; fm_mo[2] = 8'h03;
    fm_tx[0] = 8'h10; fm_tx[1] = 8'h20; fm_tx[2] = 8'h30; fm_tx[3] = 8'h00;
    run_frame(1'b0, 1'b0, 3);
    check_frame("b2b", 3);

    // Abort after 5 bits
    b_rv = n_rv; b_fe = n_ferr;
    CPOL = 1'b0; CPHA = 1'b0; DCLK = 1'b0; tx_data = 8'h99;
    cyc(4);
    nCS = 1'b0;
    cyc(8);
    spi_byte(8'hB7, 8'h99, 5, junk);
    nCS = 1'b1;
    cyc(10);
    chk("abort frame_err", n_ferr - b_fe, 1);
    chk("abort rx_valid", n_rv - b_rv, 0);
    chk("abort data_out", data_out, 8'h03);
    fm_mo[0] = 8'hFF; fm_tx[0] = 8'h6E; fm_tx[1] = 8'h00;
    run_frame(1'b0, 1'b0, 1);
    check_frame("after_abort", 1);

    // DCLK activity with nCS high
    b_rv = n_rv; b_tk = n_taken;
    for (int i = 0; i < 10; i++) begin
      DCLK = ~DCLK;
      MOSI = 1'($urandom);
      half();
      chk("idle MISO", MISO, 1'b0);
      chk("idle busy", busy, 1'b0);
    end
    chk("idle rx_valid", n_rv - b_rv, 0);
    chk("idle tx_taken", n_taken - b_tk, 0);

    // Reset in the middle of a byte
    CPOL = 1'b0; CPHA = 1'b0; DCLK = 1'b0; tx_data = 8'h55;
    cyc(4);
    nCS = 1'b0;
    cyc(8);
    spi_byte(8'h3E, 8'h55, 3, junk);
    b_rv = n_rv; b_fe = n_ferr;
    rst = 1'b1;
    cyc(1);
    chk("midrst data_out", data_out, 8'h00);
    chk("midrst MISO", MISO, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst rx_valid", rx_valid, 1'b0);
    chk("midrst tx_taken", tx_taken, 1'b0);
    chk("midrst frame_err", frame_err, 1'b0);
    nCS = 1'b1; DCLK = CPOL; rst = 1'b0;
    cyc(10);
    chk("midrst no frame_err", n_ferr - b_fe, 0);
    chk("midrst no rx_valid", n_rv - b_rv, 0);
    fm_mo[0] = 8'h81; fm_tx[0] = 8'h7E; fm_tx[1] = 8'h00;
    run_frame(1'b0, 1'b0, 1);
    check_frame("after_rst", 1);

    // Randomized frames in random modes
    for (int f = 0; f < 12; f++) begin
      int nb;
      logic [1:0] mode;
      nb   = $urandom_range(1, 3);
      mode = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) fm_mo[b] = 8'($urandom);
      for (int b = 0; b < 5; b++) fm_tx[b] = 8'($urandom);
      run_frame(mode[1], mode[0], nb);
      check_frame($sformatf("rand%0d_m%0d", f, mode), nb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL use one clock and one reset: sys_clk input 1, system clock; rst input 1, synchronous active-high reset.
REQ-002 nCS  input  1  chip select from the master, active low, asynchronous to sys_clk.
REQ-003 DCLK  input  1  SPI clock from the master, asynchronous to sys_clk.
REQ-004 MOSI  input  1  serial data from the master, MSB first.
REQ-005 MISO  output  1  serial data to the master, MSB first.
REQ-006 CPOL  input  1  idle clock level: 0 means idle low, 1 means idle high; static while nCS is low.
REQ-007 CPHA  input  1  0 means sample on the leading edge; 1 means sample on the trailing edge; static while nCS is low.
REQ-008 tx_data  input  8  byte to return to the master.
REQ-009 tx_taken  output  1  one-cycle pulse when tx_data has been latched.
REQ-010 data_out  output  8  last complete received byte.
REQ-011 rx_valid  output  1  one-cycle pulse when data_out has updated.
REQ-012 busy  output  1  high while synchronised nCS is low.
REQ-013 frame_err  output  1  one-cycle pulse when nCS deasserts mid-byte.

Function
REQ-014 nCS, DCLK and MOSI SHALL each pass through a 2-flop synchroniser in sys_clk; all internal logic SHALL use the synchronised versions only.
REQ-015 Edge detection SHALL compare synchronised DCLK with a registered copy of itself.
REQ-016 Leading edge = DCLK transition away from CPOL; trailing edge = transition back to CPOL.
REQ-017 Supported operation: sys_clk frequency >= 8x DCLK frequency; each DCLK level stable >= 3 sys_clk cycles.
REQ-018 Sample edge: leading edge if CPHA=0, trailing edge if CPHA=1.
REQ-019 Shift edge: trailing edge if CPHA=0, leading edge if CPHA=1.
REQ-020 The FSM SHALL have the states IDLE, LOAD, XFER and DONE.
REQ-021 IDLE -> LOAD on synchronised nCS falling; LOAD lasts exactly one cycle.
REQ-022 LOAD SHALL load tx_data into tx_shift, pulse tx_taken, clear bit_cnt[2:0] and go to XFER.
REQ-023 In XFER, each sample edge SHALL shift the synchronised MOSI into the LSB of rx_shift and increment bit_cnt.
REQ-024 When bit_cnt wraps 7->0 on a sample edge, the FSM SHALL go to DONE.
REQ-025 In XFER, a shift edge SHALL rotate tx_shift left by one bit.
REQ-026 CPHA=0: the shift edge following the 8th sample SHALL NOT rotate; the reload in LOAD supplies the next byte's MSB instead.
REQ-027 CPHA=1: the first leading edge of each byte SHALL NOT rotate, so the MSB set up in LOAD is driven for sample 1.
REQ-028 DONE SHALL register the completed byte into data_out and pulse rx_valid one cycle after the 8th sample edge is detected.
REQ-029 DONE -> LOAD if nCS is still low (back-to-back bytes; tx_data re-latched); DONE -> IDLE if nCS is high.
REQ-030 MISO = tx_shift[7] while synchronised nCS is low, else 0.
REQ-031 A synchronised nCS rising edge in XFER with bit_cnt != 0 SHALL pulse frame_err, leave data_out unchanged, not pulse rx_valid, and go to IDLE.
REQ-032 A synchronised nCS rising edge in XFER with bit_cnt == 0 SHALL go to IDLE silently.
REQ-033 A sample edge and an nCS rise in the same cycle SHALL be resolved nCS-first: the edge is ignored and the abort applies.
REQ-034 In IDLE, DCLK edges SHALL be ignored and rx_shift/bit_cnt SHALL hold 0.

Reset
REQ-035 On rst, in the cycle it is sampled: state=IDLE; data_out=8'h00; rx_shift=8'h00; tx_shift=8'h00; bit_cnt=0; MISO=0; rx_valid, tx_taken, frame_err, busy = 0; synchroniser flops = 1 for nCS, 0 for DCLK and MOSI.
REQ-036 rst mid-transfer SHALL abort the transfer without rx_valid or frame_err.
REQ-037 After rst, the block SHALL wait for a fresh nCS falling edge before starting.

Verification
REQ-038 Mode 0 (CPOL=0, CPHA=0), DCLK = sys_clk/10, master sends 8'hA5, tx_data=8'h3C -> tx_taken once, data_out=8'hA5, one rx_valid, master reads 8'h3C.
REQ-039 Modes 1, 2 and 3, master sends 8'h5A, tx_data=8'hC3 -> data_out=8'h5A, master reads 8'hC3 in each mode.
REQ-040 Back-to-back: nCS held low for bytes 8'h01, 8'h02, 8'h03, tx_data updated after each tx_taken to 8'h10, 8'h20, 8'h30 -> three rx_valid pulses with matching data_out; master reads 8'h10, 8'h20, 8'h30.
REQ-041 Abort: nCS rises after 5 bits -> frame_err one pulse, no rx_valid, data_out keeps its previous value; the next full byte 8'hFF is received correctly.
REQ-042 rst asserted mid-byte -> all outputs at reset values next cycle; the following transfer of 8'h81 yields data_out=8'h81.
REQ-043 Idle DCLK toggling with nCS high -> no rx_valid, no tx_taken, MISO=0, busy=0.
